// File: rtl/lut_event_monitor.sv
// lut_event_monitor
// Sequential consumer of the registered 6-input AND detector. It re-registers
// the detect bit, counts its rising edges in a saturating counter and flags a
// sticky hit once the detect has stayed high for RUN_LEN consecutive samples.
module lut_event_monitor #(
  parameter int unsigned CNT_WIDTH = 16,  // legal range 4..32
  parameter int unsigned RUN_LEN   = 4    // legal range 2..255
) (
  input  logic                 clock0,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 det_in,
  output logic                 edge_pulse,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 count_sat,
  output logic                 run_hit,
  output logic                 run_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    HIT   = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [7:0]           RUN_LAST = 8'(RUN_LEN - 1);

  // Two-stage input pipeline: det_q is the current sample, det_dly_q the
  // previous one. Both run free of enable so re-enabling into a high detect
  // does not fabricate an edge.
  logic det_q, det_dly_q;

  state_e               state_q, state_d;
  logic [7:0]           run_cnt_q, run_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 hit_q, hit_d;
  logic                 pulse_q, pulse_d;
  logic                 rise;

  // Next-state logic: clear beats disable, disable beats normal operation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    rise      = det_q & ~det_dly_q & enable;
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    hit_d     = hit_q;
    pulse_d   = rise;

    if (clear) begin
      // A rise landing on the clear cycle is dropped, pulse included.
      cnt_d     = '0;
      sat_d     = 1'b0;
      hit_d     = 1'b0;
      pulse_d   = 1'b0;
      run_cnt_d = '0;
      state_d   = enable ? ARMED : IDLE;
    end else if (!enable) begin
      // Count, saturation flag and sticky hit all hold while disabled.
      state_d   = IDLE;
      run_cnt_d = '0;
      pulse_d   = 1'b0;
    end else begin
      // Saturating counter: never wraps past all-ones.
      if (rise && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
      sat_d = sat_q | (cnt_d == CNT_MAX);

      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (det_q) begin
            state_d   = RUN;
            run_cnt_d = 8'd1;
          end
        end
        RUN: begin
          if (!det_q) begin
            state_d   = ARMED;
            run_cnt_d = '0;
          end else if (run_cnt_q == RUN_LAST) begin
            state_d   = HIT;
            run_cnt_d = '0;
            hit_d     = 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + 8'd1;
          end
        end
        HIT: state_d = HIT;
        default: begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock0) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      det_q     <= 1'b0;
      det_dly_q <= 1'b0;
      state_q   <= IDLE;
      run_cnt_q <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      hit_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      det_q     <= det_in;
      det_dly_q <= det_q;
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      hit_q     <= hit_d;
      pulse_q   <= pulse_d;
    end
  end

  assign edge_pulse  = pulse_q;
  assign event_count = cnt_q;
  assign count_sat   = sat_q;
  assign run_hit     = hit_q;
  assign run_active  = (state_q == RUN);

endmodule

// File: tb/tb_lut_event_monitor.sv
// Directed bench for lut_event_monitor (CNT_WIDTH=4 so saturation is reachable,
// RUN_LEN=4). Inputs change 1 time unit after a rising edge; outputs are
// compared at that same point, i.e. they reflect the edge just taken.
module tb_lut_event_monitor;

  localparam int unsigned CW = 4;
  localparam int unsigned RL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic          det = 1'b0;
  logic          edge_pulse;
  logic [CW-1:0] event_count;
  logic          count_sat;
  logic          run_hit;
  logic          run_active;

  int n_checks = 0;
  int n_pass   = 0;

  lut_event_monitor #(.CNT_WIDTH(CW), .RUN_LEN(RL)) dut (
    .clock0     (clk),
    .reset      (rst),
    .enable     (en),
    .clear      (clr),
    .det_in     (det),
    .edge_pulse (edge_pulse),
    .event_count(event_count),
    .count_sat  (count_sat),
    .run_hit    (run_hit),
    .run_active (run_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, en, clr, det;
    logic          pulse;
    logic [CW-1:0] cnt;
    logic          sat, hit, act;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, e, c, d, p, input int cnt,
                              input logic s, h, a);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.det = d;
    v.pulse = p; v.cnt = CW'(cnt); v.sat = s; v.hit = h; v.act = a;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick(input logic r, e, c, d);
    rst = r; en = e; clr = c; det = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string name, input logic p, input int cnt,
                            input logic s, h, a);
    check({name, " edge_pulse"},  32'(edge_pulse),  32'(p));
    check({name, " event_count"}, 32'(event_count), 32'(cnt));
    check({name, " count_sat"},   32'(count_sat),   32'(s));
    check({name, " run_hit"},     32'(run_hit),     32'(h));
    check({name, " run_active"},  32'(run_active),  32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, then det 0x3 1x2 0x2 1x1: two pulses, count 2, no hit.
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 1,1,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,1,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,1,0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,2,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,2,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,2,0,0,0));
    // Four high samples: active after N+1..N+3, hit at N+4, hit sticks.
    tbl.push_back(mk(0,1,0,1, 0,2,0,0,0));
    tbl.push_back(mk(0,1,0,1, 1,3,0,0,1));
    tbl.push_back(mk(0,1,0,1, 0,3,0,0,1));
    tbl.push_back(mk(0,1,0,1, 0,3,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,3,0,1,0));
    tbl.push_back(mk(0,1,0,0, 0,3,0,1,0));
    tbl.push_back(mk(0,1,0,0, 0,3,0,1,0));
    // Clear, then high x3, low x1, high x4: hit only after second burst.
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 1,1,0,0,1));
    tbl.push_back(mk(0,1,0,1, 0,1,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,1,0,0,1));
    tbl.push_back(mk(0,1,0,1, 0,1,0,0,0));
    tbl.push_back(mk(0,1,0,1, 1,2,0,0,1));
    tbl.push_back(mk(0,1,0,1, 0,2,0,0,1));
    tbl.push_back(mk(0,1,0,1, 0,2,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,2,0,1,0));
    tbl.push_back(mk(0,1,0,0, 0,2,0,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].det);
      expect_all($sformatf("row%0d", i), tbl[i].pulse, int'(tbl[i].cnt),
                 tbl[i].sat, tbl[i].hit, tbl[i].act);
    end

    // Saturation: 20 rising edges into a 4-bit counter, no wrap.
    tick(0,1,1,0);
    check("sat clear count", 32'(event_count), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick(0,1,0,1);
      tick(0,1,0,0);
      check($sformatf("sat edge%0d count", k), 32'(event_count),
            32'((k > 15) ? 15 : k));
      check($sformatf("sat edge%0d flag", k), 32'(count_sat),
            32'((k >= 15) ? 1 : 0));
      if (k <= 15) check($sformatf("sat edge%0d pulse", k), 32'(edge_pulse), 32'd1);
    end

    // Rise coincident with clear is discarded.
    tick(0,1,0,0);
    tick(0,1,0,1);
    tick(0,1,1,1);
    expect_all("clr_rise", 0, 0, 0, 0, 0);
    tick(0,1,0,1);
    expect_all("clr_after", 0, 0, 0, 0, 1);

    // Disable during RUN: IDLE next edge, count held, no pulses, no edge
    // on re-enable with det already high.
    tick(0,1,0,0);
    tick(0,1,0,0);
    tick(0,1,0,1);
    tick(0,1,0,1);
    expect_all("dis_run", 1, 1, 0, 0, 1);
    tick(0,0,0,1);
    expect_all("dis_idle", 0, 1, 0, 0, 0);
    tick(0,0,0,0);
    tick(0,0,0,1);
    tick(0,0,0,1);
    expect_all("dis_gated", 0, 1, 0, 0, 0);
    tick(0,1,0,1);
    expect_all("reen_noedge", 0, 1, 0, 0, 0);
    tick(0,1,0,1);
    expect_all("reen_run", 0, 1, 0, 0, 1);

    // Build count 5 with a hit, check hold across disable, then reset.
    tick(0,1,1,0);
    for (int k = 0; k < 4; k++) begin
      tick(0,1,0,1);
      tick(0,1,0,0);
    end
    check("build count4", 32'(event_count), 32'd4);
    for (int k = 0; k < 5; k++) tick(0,1,0,1);
    expect_all("build hit", 0, 5, 0, 1, 0);
    tick(0,0,0,1);
    expect_all("hit_hold_dis", 0, 5, 0, 1, 0);
    tick(0,1,0,1);
    expect_all("hit_hold_reen", 0, 5, 0, 1, 0);
    tick(1,1,0,1);
    expect_all("midreset", 0, 0, 0, 0, 0);
    tick(0,1,0,1);
    expect_all("post_reset1", 0, 0, 0, 0, 0);
    tick(0,1,0,1);
    expect_all("post_reset2", 1, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
